cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
Parametrised successor to the single-cycle CP0. It holds Count, Compare, Status, Cause and EPC for the single-cycle MIPS datapath. It adds hardware interrupt lines, software interrupts, a Count/Compare timer and an exception-priority arbiter. It sits beside the register file, is driven by the control unit's cp0 opcode, and supplies read data, the ERET target and the exception redirect to the PC logic.

Parameters:
NUM_HW_INT, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2+i].
TIMER_EN, 1, 1 = Count/Compare timer present; 0 = Count reads 0 and TI never sets.
EXC_VECTOR, 32'h0000_0380, PC redirect target for every exception or interrupt.
COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (power of two, 1..8).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
resetn  in  1  asynchronous, active-low reset.
cp0_op  in  3  000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET, 101 BREAK.
cs  in  5  CP0 register number.
sel  in  3  CP0 select field.
wdata  in  32  MTC0 write data (busB).
pc  in  30  word address of the current instruction (PC[31:2]).
hw_int  in  NUM_HW_INT  level-sensitive external interrupt requests.
rdata  out  32  MFC0 read data.
epc_out  out  32  ERET target; always equals EPC.
exc_req  out  1  take exception this cycle; PC logic must load exc_vector.
exc_vector  out  32  constant EXC_VECTOR.
int_pending  out  1  unmasked interrupt present.

Behaviour:
- Register map, addr = {cs, sel}:
  - Count 72 (9,0): read/write.
  - Compare 88 (11,0): read/write.
  - Status 96 (12,0): IM[15:8], EXL[1], IE[0] writable; other bits read 0.
  - Cause 104 (13,0): TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] writable.
  - EPC 112 (14,0): read/write.
  - Any other address reads 0; writes to it are ignored.
- Reset (resetn low, asynchronous): all registers 0, the divider counter 0, and every output 0 except exc_vector.
- rdata: combinational, zero latency; valid only when cp0_op=001, otherwise 0.
- Cause.IP[2+i] is registered from hw_int[i] each cycle, giving one cycle of latency. Unused IP bits read 0.
- IP[7] is hw_int[5] OR TI; when NUM_HW_INT<6, IP[7] is TI alone.
- Timer (TIMER_EN=1):
  - Count increments by 1 when the divider wraps, and wraps from 0xFFFF_FFFF to 0.
  - An MTC0 to Count loads wdata and resets the divider; the write overrides the increment in that cycle.
  - TI sets on the edge after Count==Compare and stays set until an MTC0 to Compare clears it.
- int_pending = IE & ~EXL & |(Cause.IP & Status.IM); combinational.
- Exception take, combinational priority within the cycle:
  - int_pending, ExcCode 0, has highest priority.
  - Otherwise cp0_op=011 gives ExcCode 8; cp0_op=101 gives ExcCode 9.
  - SYSCALL/BREAK are taken even when EXL=1; they overwrite EPC.
- exc_req is high in the cycle the exception is taken. On the next edge:
  - EPC <= {pc, 2'b00};
  - Cause.ExcCode <= code;
  - Status.EXL <= 1.
- ERET (cp0_op=100): on the edge, EXL <= 0. If an interrupt is pending in the same cycle, the interrupt wins and ERET is suppressed: EXL stays 1 and EPC <= pc.
- Simultaneous events:
  - A taken exception suppresses any MTC0 in the same cycle.
  - An MTC0 to Compare while Count==Compare leaves TI clear.
  - An MTC0 to Status that sets IE takes effect on the next cycle.
- Reset mid-operation clears EXL and any pending TI immediately.

Decomposition:
- Shared package cp0_pkg holds:
  - the cp0_op encodings (CP0_NONE..CP0_BREAK);
  - the register address constants (ADDR_COUNT=72 ... ADDR_EPC=112);
  - the ExcCode constants (EXC_INT=0, EXC_SYS=8, EXC_BP=9);
  - the Status/Cause bit-position constants.
- Natural sub-module: cp0_timer. It contains the divider, Count and Compare, and takes a load strobe and load data, giving TI out.

Test Plan:
- Reset then MFC0 of all five addresses, plus address 0 -> rdata=0 in every case; exc_req=0.
- MTC0 Status=0x0000_8001, Compare=20, Count=0, COUNT_DIV=2 -> TI sets about 40 cycles later; exc_req=1 for one cycle, EPC={pc,00}, ExcCode=0, EXL=1; next cycle int_pending=0.
- SYSCALL at pc=0x0000_1000 -> exc_req=1, EPC=0x0000_1000, Cause[6:2]=8, EXL=1. Then ERET -> epc_out=0x0000_1000 and EXL=0 after the edge.
- hw_int[0]=1 with IM[2]=1 and IE=1 while cp0_op=010 targets EPC -> interrupt taken, EPC=pc (the MTC0 data is discarded), IP[2]=1 readable.
- MTC0 Cause=0x0000_0300 with IM[9:8]=11 and IE=1 -> software interrupt taken next cycle. Writing Cause=0 clears IP[9:8], and int_pending drops.
- resetn pulled low while EXL=1 and TI=1 -> Status, Cause, Count and EPC all read 0 immediately after release.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception unit: opcode encodings, register
// addresses, exception codes and Status/Cause field positions.
package cp0_pkg;

   typedef enum logic [2:0] {
      CP0_NONE    = 3'b000,
      CP0_MFC0    = 3'b001,
      CP0_MTC0    = 3'b010,
      CP0_SYSCALL = 3'b011,
      CP0_ERET    = 3'b100,
      CP0_BREAK   = 3'b101
   } cp0_op_e;

   localparam logic [7:0] ADDR_COUNT   = 8'd72;
   localparam logic [7:0] ADDR_COMPARE = 8'd88;
   localparam logic [7:0] ADDR_STATUS  = 8'd96;
   localparam logic [7:0] ADDR_CAUSE   = 8'd104;
   localparam logic [7:0] ADDR_EPC     = 8'd112;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_BP  = 5'd9;

   localparam int STATUS_IE    = 0;
   localparam int STATUS_EXL   = 1;
   localparam int STATUS_IM_LO = 8;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_IP_LO  = 8;
   localparam int CAUSE_TI     = 30;

   function automatic logic [7:0] cp0_addr(input logic [4:0] cs, input logic [2:0] sel);
      return {cs, sel};
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky TI flag.
module cp0_timer
   import cp0_pkg::*;
#(
   parameter bit TIMER_EN  = 1'b1,
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_load,
   input  logic        compare_load,
   input  logic [31:0] load_data,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam logic [2:0] DIV_LAST = 3'(COUNT_DIV - 1);

   logic [2:0]  div_q;
   logic [31:0] count_q;
   logic        ti_q;

   // A Compare write clears TI even when the match condition holds that cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q   <= '0;
         count_q <= '0;
         compare <= '0;
         ti_q    <= 1'b0;
      end else begin
         if (count_load) begin
            count_q <= load_data;
            div_q   <= '0;
         end else if (div_q == DIV_LAST) begin
            div_q   <= '0;
            count_q <= count_q + 32'd1;
         end else begin
            div_q <= div_q + 3'd1;
         end

         if (compare_load) begin
            compare <= load_data;
            ti_q    <= 1'b0;
         end else if (count_q == compare) begin
            ti_q <= 1'b1;
         end
      end
   end

   assign count = TIMER_EN ? count_q : 32'd0;
   assign ti    = TIMER_EN & ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 with Status/Cause/EPC, hardware and software interrupts, timer and the
// exception-priority arbiter that redirects the single-cycle datapath.
module cp0_exc_unit
   import cp0_pkg::*;
#(
   parameter int          NUM_HW_INT = 6,
   parameter bit          TIMER_EN   = 1'b1,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
   parameter int          COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [2:0]            cp0_op,
   input  logic [4:0]            cs,
   input  logic [2:0]            sel,
   input  logic [31:0]           wdata,
   input  logic [29:0]           pc,
   input  logic [NUM_HW_INT-1:0] hw_int,
   output logic [31:0]           rdata,
   output logic [31:0]           epc_out,
   output logic                  exc_req,
   output logic [31:0]           exc_vector,
   output logic                  int_pending
);

   logic [7:0]  addr;
   logic [7:0]  status_im;
   logic        status_exl;
   logic        status_ie;
   logic [1:0]  cause_sw;
   logic [5:0]  hw_q;
   logic [5:0]  hw_ext;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [7:0]  ip;
   logic [31:0] status_val;
   logic [31:0] cause_val;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;
   logic        exc_take;
   logic [4:0]  code_next;
   logic        mtc0_we;

   assign addr = cp0_addr(cs, sel);

   // Lines beyond NUM_HW_INT are tied off so their IP bits always read 0.
   always_comb begin
      hw_ext                   = '0;
      hw_ext[NUM_HW_INT-1:0]   = hw_int;
   end

   assign ip         = {hw_q[5] | ti, hw_q[4:0], cause_sw};
   assign status_val = {16'd0, status_im, 6'd0, status_exl, status_ie};
   assign cause_val  = {1'b0, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};

   assign int_pending = status_ie & ~status_exl & |(ip & status_im);
   assign exc_take    = resetn & (int_pending || cp0_op == CP0_SYSCALL || cp0_op == CP0_BREAK);
   assign code_next   = int_pending ? EXC_INT : ((cp0_op == CP0_SYSCALL) ? EXC_SYS : EXC_BP);
   assign mtc0_we     = (cp0_op == CP0_MTC0) & ~exc_take;

   assign exc_req    = exc_take;
   assign exc_vector = EXC_VECTOR;
   assign epc_out    = epc;

   cp0_timer #(
      .TIMER_EN  (TIMER_EN),
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk          (clk),
      .resetn       (resetn),
      .count_load   (mtc0_we && addr == ADDR_COUNT),
      .compare_load (mtc0_we && addr == ADDR_COMPARE),
      .load_data    (wdata),
      .count        (count),
      .compare      (compare),
      .ti           (ti)
   );

   always_comb begin
      rdata = 32'd0;
      if (cp0_op == CP0_MFC0) begin
         case (addr)
            ADDR_COUNT:   rdata = count;
            ADDR_COMPARE: rdata = compare;
            ADDR_STATUS:  rdata = status_val;
            ADDR_CAUSE:   rdata = cause_val;
            ADDR_EPC:     rdata = epc;
            default:      rdata = 32'd0;
         endcase
      end
   end

   // Exception entry outranks ERET, which outranks register writes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_im  <= '0;
         status_exl <= 1'b0;
         status_ie  <= 1'b0;
         cause_sw   <= '0;
         hw_q       <= '0;
         exc_code   <= '0;
         epc        <= '0;
      end else begin
         hw_q <= hw_ext;
         if (exc_take) begin
            epc        <= {pc, 2'b00};
            exc_code   <= code_next;
            status_exl <= 1'b1;
         end else if (cp0_op == CP0_ERET) begin
            status_exl <= 1'b0;
         end else if (mtc0_we) begin
            case (addr)
               ADDR_STATUS: begin
                  status_im  <= wdata[STATUS_IM_LO +: 8];
                  status_exl <= wdata[STATUS_EXL];
                  status_ie  <= wdata[STATUS_IE];
               end
               ADDR_CAUSE: cause_sw <= wdata[CAUSE_IP_LO +: 2];
               ADDR_EPC:   epc      <= wdata;
               default:    ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: directed vectors queue expected reads and
// exceptions; a negedge monitor pops and compares them as the DUT presents them.
module tb_cp0_exc_unit;
   import cp0_pkg::*;

   logic        clk;
   logic        resetn;
   logic [2:0]  cp0_op;
   logic [4:0]  cs;
   logic [2:0]  sel;
   logic [31:0] wdata;
   logic [29:0] pc;
   logic [5:0]  hw_int;
   logic [31:0] rdata;
   logic [31:0] epc_out;
   logic        exc_req;
   logic [31:0] exc_vector;
   logic        int_pending;

   int checks;
   int failures;

   string       rd_name_q[$];
   logic [31:0] rd_data_q[$];
   logic        rd_int_q[$];
   string       exc_name_q[$];
   logic [31:0] exc_epc_q[$];

   logic        epc_chk_pending;
   string       epc_chk_name;
   logic [31:0] epc_chk_val;

   cp0_exc_unit #(
      .NUM_HW_INT (6),
      .TIMER_EN   (1'b1),
      .EXC_VECTOR (32'h0000_0380),
      .COUNT_DIV  (2)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .cp0_op      (cp0_op),
      .cs          (cs),
      .sel         (sel),
      .wdata       (wdata),
      .pc          (pc),
      .hw_int      (hw_int),
      .rdata       (rdata),
      .epc_out     (epc_out),
      .exc_req     (exc_req),
      .exc_vector  (exc_vector),
      .int_pending (int_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a,
                                input logic [31:0] wd, input logic [29:0] p);
      @(posedge clk);
      #1;
      cp0_op = op;
      cs     = a[7:3];
      sel    = a[2:0];
      wdata  = wd;
      pc     = p;
   endtask

   task automatic readReg(input string name, input logic [7:0] a,
                          input logic [31:0] exp, input logic exp_int);
      rd_name_q.push_back(name);
      rd_data_q.push_back(exp);
      rd_int_q.push_back(exp_int);
      applyStimulus(CP0_MFC0, a, 32'd0, pc);
   endtask

   task automatic expectExc(input string name, input logic [31:0] exp_epc);
      exc_name_q.push_back(name);
      exc_epc_q.push_back(exp_epc);
   endtask

   // Monitor: MFC0 cycles and exc_req cycles are the DUT's observable outputs.
   initial begin
      string       nm;
      logic [31:0] ev;
      logic        ei;
      epc_chk_pending = 1'b0;
      forever begin
         @(negedge clk);
         if (epc_chk_pending) begin
            checkOutput({epc_chk_name, " epc_out"}, epc_out, epc_chk_val);
            epc_chk_pending = 1'b0;
         end
         if (cp0_op == CP0_MFC0) begin
            if (rd_name_q.size() == 0) begin
               checkOutput("unexpected MFC0", 32'd1, 32'd0);
            end else begin
               nm = rd_name_q.pop_front();
               ev = rd_data_q.pop_front();
               ei = rd_int_q.pop_front();
               checkOutput({nm, " rdata"}, rdata, ev);
               checkOutput({nm, " int_pending"}, {31'd0, int_pending}, {31'd0, ei});
            end
         end
         if (exc_req) begin
            if (exc_name_q.size() == 0) begin
               checkOutput("unexpected exc_req", {31'd0, exc_req}, 32'd0);
            end else begin
               epc_chk_name    = exc_name_q.pop_front();
               epc_chk_val     = exc_epc_q.pop_front();
               epc_chk_pending = 1'b1;
               checkOutput({epc_chk_name, " exc_vector"}, exc_vector, 32'h0000_0380);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit done;
      checks   = 0;
      failures = 0;
      resetn   = 1'b0;
      cp0_op   = CP0_NONE;
      cs       = '0;
      sel      = '0;
      wdata    = '0;
      pc       = '0;
      hw_int   = '0;
      repeat (2) @(posedge clk);

      // Reads and a SYSCALL while held in reset: everything reads 0, no exception.
      readReg("rst count",   ADDR_COUNT,   32'd0, 1'b0);
      readReg("rst compare", ADDR_COMPARE, 32'd0, 1'b0);
      readReg("rst status",  ADDR_STATUS,  32'd0, 1'b0);
      readReg("rst cause",   ADDR_CAUSE,   32'd0, 1'b0);
      readReg("rst epc",     ADDR_EPC,     32'd0, 1'b0);
      readReg("rst addr0",   8'd0,         32'd0, 1'b0);
      applyStimulus(CP0_SYSCALL, 8'd0, 32'd0, 30'h10);
      applyStimulus(CP0_NONE, 8'd0, 32'd0, 30'h0);
      #1 resetn = 1'b1;

      // Timer interrupt: Compare=20, Count=0, divide-by-2 -> TI roughly 41 edges later.
      applyStimulus(CP0_MTC0, ADDR_COMPARE, 32'd20, 30'h0);
      applyStimulus(CP0_MTC0, ADDR_COUNT,   32'd0,  30'h0);
      applyStimulus(CP0_MTC0, ADDR_STATUS,  32'h0000_8001, 30'h0);
      expectExc("timer", 32'h0000_0400);
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         applyStimulus(CP0_NONE, 8'd0, 32'd0, 30'h100);
         @(negedge clk);
         #1;
         if (exc_name_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         checkOutput("timer exc timeout", 32'd0, 32'd1);
         exc_name_q.delete();
         exc_epc_q.delete();
      end
      readReg("timer status", ADDR_STATUS, 32'h0000_8003, 1'b0);
      readReg("timer cause",  ADDR_CAUSE,  32'h4000_8000, 1'b0);
      readReg("timer epc",    ADDR_EPC,    32'h0000_0400, 1'b0);
      applyStimulus(CP0_MTC0, ADDR_COMPARE, 32'hFFFF_FFFF, 30'h100);
      applyStimulus(CP0_MTC0, ADDR_STATUS,  32'd0, 30'h100);
      readReg("ti cleared cause", ADDR_CAUSE, 32'd0, 1'b0);

      // SYSCALL then ERET.
      expectExc("syscall", 32'h0000_1000);
      applyStimulus(CP0_SYSCALL, 8'd0, 32'd0, 30'h400);
      readReg("sys cause",  ADDR_CAUSE,  32'h0000_0020, 1'b0);
      readReg("sys status", ADDR_STATUS, 32'h0000_0002, 1'b0);
      applyStimulus(CP0_ERET, 8'd0, 32'd0, 30'h401);
      readReg("eret status", ADDR_STATUS, 32'd0, 1'b0);
      readReg("eret epc",    ADDR_EPC,    32'h0000_1000, 1'b0);

      // Hardware interrupt beats an MTC0 to EPC in the same cycle.
      applyStimulus(CP0_MTC0, ADDR_STATUS, 32'h0000_0401, 30'h200);
      applyStimulus(CP0_NONE, 8'd0, 32'd0, 30'h200);
      hw_int = 6'b000001;
      expectExc("hwint", 32'h0000_0800);
      applyStimulus(CP0_MTC0, ADDR_EPC, 32'hDEAD_BEEF, 30'h200);
      readReg("hw epc",    ADDR_EPC,    32'h0000_0800, 1'b0);
      readReg("hw cause",  ADDR_CAUSE,  32'h0000_0400, 1'b0);
      readReg("hw status", ADDR_STATUS, 32'h0000_0403, 1'b0);
      readReg("unmapped",  8'd97,       32'd0, 1'b0);
      hw_int = 6'b000000;
      applyStimulus(CP0_MTC0, ADDR_STATUS, 32'd0, 30'h200);

      // Software interrupt via Cause.IP[9:8], then cleared by writing Cause=0.
      applyStimulus(CP0_MTC0, ADDR_STATUS, 32'h0000_0301, 30'h300);
      applyStimulus(CP0_MTC0, ADDR_CAUSE,  32'h0000_0300, 30'h300);
      expectExc("swint", 32'h0000_0C00);
      readReg("sw cause pend", ADDR_CAUSE, 32'h0000_0300, 1'b1);
      applyStimulus(CP0_MTC0, ADDR_CAUSE, 32'd0, 30'h300);
      readReg("sw cause clr", ADDR_CAUSE, 32'd0, 1'b0);
      applyStimulus(CP0_MTC0, ADDR_STATUS, 32'h0000_0301, 30'h300);
      readReg("sw status", ADDR_STATUS, 32'h0000_0301, 1'b0);

      // Build EXL=1 and TI=1, then reset mid-operation.
      applyStimulus(CP0_MTC0, ADDR_COUNT,   32'd5, 30'h40);
      applyStimulus(CP0_MTC0, ADDR_COMPARE, 32'd5, 30'h40);
      expectExc("sys2", 32'h0000_0100);
      applyStimulus(CP0_SYSCALL, 8'd0, 32'd0, 30'h40);
      readReg("pre-rst cause",  ADDR_CAUSE,  32'h4000_8020, 1'b0);
      readReg("pre-rst status", ADDR_STATUS, 32'h0000_0303, 1'b0);
      readReg("in-rst status",  ADDR_STATUS, 32'd0, 1'b0);
      #1 resetn = 1'b0;
      readReg("in-rst cause",   ADDR_CAUSE,  32'd0, 1'b0);
      readReg("rel cause",      ADDR_CAUSE,  32'd0, 1'b0);
      #1 resetn = 1'b1;
      readReg("rel count",  ADDR_COUNT,  32'd0, 1'b0);
      readReg("rel status", ADDR_STATUS, 32'd0, 1'b0);
      readReg("rel epc",    ADDR_EPC,    32'd0, 1'b0);
      applyStimulus(CP0_NONE, 8'd0, 32'd0, 30'h0);
      repeat (3) @(posedge clk);

      while (rd_name_q.size() != 0) begin
         checkOutput({rd_name_q.pop_front(), " never observed"}, 32'd0, 32'd1);
         void'(rd_data_q.pop_front());
         void'(rd_int_q.pop_front());
      end
      while (exc_name_q.size() != 0) begin
         checkOutput({exc_name_q.pop_front(), " exc_req never seen"}, 32'd0, 32'd1);
         void'(exc_epc_q.pop_front());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
